// File: rtl/decoder_8b10b_mlane_if.sv
// Symbol-in / byte-out bundle for the multi-lane 8b/10b decoder.
interface decoder_8b10b_mlane_if #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned ERR_CNT_W = 16
);
  logic                  DVI;
  logic [10*LANES-1:0]   DI;
  logic                  ERR_CLR;
  logic                  DVO;
  logic [8*LANES-1:0]    DO;
  logic [LANES-1:0]      K;
  logic [LANES-1:0]      COMMA;
  logic [LANES-1:0]      CODE_ERR;
  logic [LANES-1:0]      DISP_ERR;
  logic                  RD_OUT;
  logic [ERR_CNT_W-1:0]  ERR_CNT;

  modport master (
    output DVI, DI, ERR_CLR,
    input  DVO, DO, K, COMMA, CODE_ERR, DISP_ERR, RD_OUT, ERR_CNT
  );

  modport slave (
    input  DVI, DI, ERR_CLR,
    output DVO, DO, K, COMMA, CODE_ERR, DISP_ERR, RD_OUT, ERR_CNT
  );
endinterface

// File: rtl/decoder_8b10b_mlane.sv
// Registered LANES-wide 8b/10b decoder with running disparity chained lane 0 -> LANES-1,
// per-lane code/disparity flags, comma detect and a saturating error counter.
module decoder_8b10b_mlane #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned ERR_CNT_W = 16,
  parameter bit          RD_INIT   = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RST,
  decoder_8b10b_mlane_if.slave   bus
);

  localparam int unsigned CNT_W  = $clog2(LANES + 1);
  localparam int unsigned SUM_W  = ((ERR_CNT_W > CNT_W) ? ERR_CNT_W : CNT_W) + 1;
  localparam int unsigned RES_W  = 13;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  // 5b/6b table, both RD columns: returns {valid, EDCBA}
  function automatic logic [5:0] dec6(input logic [5:0] s);
    case (s)
      6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
      6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
      6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
      6'b110001:            dec6 = {1'b1, 5'd3};
      6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
      6'b101001:            dec6 = {1'b1, 5'd5};
      6'b011001:            dec6 = {1'b1, 5'd6};
      6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
      6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
      6'b100101:            dec6 = {1'b1, 5'd9};
      6'b010101:            dec6 = {1'b1, 5'd10};
      6'b110100:            dec6 = {1'b1, 5'd11};
      6'b001101:            dec6 = {1'b1, 5'd12};
      6'b101100:            dec6 = {1'b1, 5'd13};
      6'b011100:            dec6 = {1'b1, 5'd14};
      6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
      6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
      6'b100011:            dec6 = {1'b1, 5'd17};
      6'b010011:            dec6 = {1'b1, 5'd18};
      6'b110010:            dec6 = {1'b1, 5'd19};
      6'b001011:            dec6 = {1'b1, 5'd20};
      6'b101010:            dec6 = {1'b1, 5'd21};
      6'b011010:            dec6 = {1'b1, 5'd22};
      6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
      6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
      6'b100110:            dec6 = {1'b1, 5'd25};
      6'b010110:            dec6 = {1'b1, 5'd26};
      6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
      6'b001110:            dec6 = {1'b1, 5'd28};
      6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
      6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
      6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
      default:              dec6 = 6'd0;
    endcase
  endfunction

  // 3b/4b table incl. P7 and A7: returns {valid, HGF}
  function automatic logic [3:0] dec4(input logic [3:0] s);
    case (s)
      4'b1011, 4'b0100:                   dec4 = {1'b1, 3'd0};
      4'b1001:                            dec4 = {1'b1, 3'd1};
      4'b0101:                            dec4 = {1'b1, 3'd2};
      4'b1100, 4'b0011:                   dec4 = {1'b1, 3'd3};
      4'b1101, 4'b0010:                   dec4 = {1'b1, 3'd4};
      4'b1010:                            dec4 = {1'b1, 3'd5};
      4'b0110:                            dec4 = {1'b1, 3'd6};
      4'b1110, 4'b0001, 4'b0111, 4'b1000: dec4 = {1'b1, 3'd7};
      default:                            dec4 = 4'd0;
    endcase
  endfunction

  // One symbol: returns {rd_out, disp_err, code_err, comma, k, byte}
  function automatic logic [12:0] decode_lane(input logic [9:0] sym, input logic rd_in);
    logic [5:0] s6;
    logic [3:0] s4, f4, d4;
    logic [5:0] d6;
    logic [4:0] x;
    logic       is_k28, kf, ok, a7m, a7p, k7m, k7p;
    logic       pos6, neg6, pos4, neg4, rd_mid, rd_o, derr, comma;
    s6     = sym[9:4];
    s4     = sym[3:0];
    is_k28 = (s6 == 6'b001111) || (s6 == 6'b110000);
    // K28 4b codes after 110000 are the complement of those after 001111
    f4     = (s6 == 6'b110000) ? ~s4 : s4;
    d6     = dec6(s6);
    d4     = dec4(is_k28 ? f4 : s4);
    a7m    = (s6 == 6'b100011) || (s6 == 6'b010011) || (s6 == 6'b001011);
    a7p    = (s6 == 6'b110100) || (s6 == 6'b101100) || (s6 == 6'b011100);
    k7m    = (s6 == 6'b111010) || (s6 == 6'b110110) || (s6 == 6'b101110) || (s6 == 6'b011110);
    k7p    = (s6 == 6'b000101) || (s6 == 6'b001001) || (s6 == 6'b010001) || (s6 == 6'b100001);
    kf     = 1'b0;
    ok     = d6[5] && d4[3];
    if (is_k28) begin
      kf = 1'b1;
      case (f4)
        4'b0100, 4'b1001, 4'b0101, 4'b0011,
        4'b0010, 4'b1010, 4'b0110, 4'b1000: ok = 1'b1;
        default:                            ok = 1'b0;
      endcase
    end else begin
      // x.7 alternates are only legal after the sub-blocks that need them
      case (s4)
        4'b0111: if (k7p) kf = 1'b1; else if (!a7m) ok = 1'b0;
        4'b1000: if (k7m) kf = 1'b1; else if (!a7p) ok = 1'b0;
        4'b1110: if (a7m) ok = 1'b0;
        4'b0001: if (a7p) ok = 1'b0;
        default: ;
      endcase
    end
    x      = is_k28 ? 5'd28 : d6[4:0];
    comma  = ok && is_k28 && ((d4[2:0] == 3'd1) || (d4[2:0] == 3'd5) || (d4[2:0] == 3'd7));
    pos6   = $countones(s6) > 3;
    neg6   = $countones(s6) < 3;
    pos4   = $countones(s4) > 2;
    neg4   = $countones(s4) < 2;
    derr   = (pos6 && rd_in) || (neg6 && !rd_in) ||
             ((s6 == 6'b111000) && rd_in) || ((s6 == 6'b000111) && !rd_in);
    rd_mid = pos6 ? 1'b1 : (neg6 ? 1'b0 : rd_in);
    derr   = derr || (pos4 && rd_mid) || (neg4 && !rd_mid) ||
             ((s4 == 4'b1100) && rd_mid) || ((s4 == 4'b0011) && !rd_mid);
    rd_o   = pos4 ? 1'b1 : (neg4 ? 1'b0 : rd_mid);
    decode_lane = {rd_o, derr, !ok, comma, ok && kf, ok ? {d4[2:0], x} : 8'h00};
  endfunction

  logic                 r_dvo;
  logic [8*LANES-1:0]   r_do;
  logic [LANES-1:0]     r_k, r_comma, r_code_err, r_disp_err;
  logic                 r_rd;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [8*LANES-1:0]   w_do;
  logic [LANES-1:0]     w_k, w_comma, w_code_err, w_disp_err;
  logic                 w_rd_nxt;
  logic [CNT_W-1:0]     w_nerr;
  logic [SUM_W-1:0]     w_sum;
  logic [ERR_CNT_W-1:0] w_err_cnt_nxt;

  // Lane decode with running disparity rippling from lane 0 upward
  always_comb begin
    logic             rd_v;
    logic [RES_W-1:0] res_v;
    rd_v       = r_rd;
    w_do       = '0;
    w_k        = '0;
    w_comma    = '0;
    w_code_err = '0;
    w_disp_err = '0;
    for (int n = 0; n < LANES; n++) begin
      res_v          = decode_lane(bus.DI[10*n +: 10], rd_v);
      rd_v           = res_v[12];
      w_disp_err[n]  = res_v[11];
      w_code_err[n]  = res_v[10];
      w_comma[n]     = res_v[9];
      w_k[n]         = res_v[8];
      w_do[8*n +: 8] = res_v[7:0];
    end
    w_rd_nxt = rd_v;
  end

  // Saturating error accumulation; a clear restarts from this word's errors
  always_comb begin
    w_nerr = CNT_W'($countones(w_code_err | w_disp_err));
    w_sum  = (bus.ERR_CLR ? SUM_W'(0) : SUM_W'(r_err_cnt)) + SUM_W'(w_nerr);
    if (bus.DVI)
      w_err_cnt_nxt = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : ERR_CNT_W'(w_sum);
    else if (bus.ERR_CLR)
      w_err_cnt_nxt = '0;
    else
      w_err_cnt_nxt = r_err_cnt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dvo      <= 1'b0;
      r_do       <= '0;
      r_k        <= '0;
      r_comma    <= '0;
      r_code_err <= '0;
      r_disp_err <= '0;
      r_rd       <= RD_INIT;
      r_err_cnt  <= '0;
    end else begin
      r_dvo     <= bus.DVI;
      r_err_cnt <= w_err_cnt_nxt;
      if (bus.DVI) begin
        r_do       <= w_do;
        r_k        <= w_k;
        r_comma    <= w_comma;
        r_code_err <= w_code_err;
        r_disp_err <= w_disp_err;
        r_rd       <= w_rd_nxt;
      end
    end
  end

  assign bus.DVO      = r_dvo;
  assign bus.DO       = r_do;
  assign bus.K        = r_k;
  assign bus.COMMA    = r_comma;
  assign bus.CODE_ERR = r_code_err;
  assign bus.DISP_ERR = r_disp_err;
  assign bus.RD_OUT   = r_rd;
  assign bus.ERR_CNT  = r_err_cnt;

endmodule

// File: tb/tb_decoder_8b10b_mlane.sv
// Directed-vector bench for decoder_8b10b_mlane: a 2-lane/16-bit-counter instance and a
// 2-lane/4-bit-counter instance for saturation and clear behaviour.
module tb_decoder_8b10b_mlane;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errors;

  decoder_8b10b_mlane_if #(.LANES(2), .ERR_CNT_W(16)) bus  ();
  decoder_8b10b_mlane_if #(.LANES(2), .ERR_CNT_W(4))  bus4 ();

  decoder_8b10b_mlane #(.LANES(2), .ERR_CNT_W(16), .RD_INIT(1'b0)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  decoder_8b10b_mlane #(.LANES(2), .ERR_CNT_W(4), .RD_INIT(1'b0)) u_dut4 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus4)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic dvo_e, input logic [15:0] do_e,
                            input logic [1:0] k_e, input logic [1:0] comma_e,
                            input logic [1:0] code_e, input logic [1:0] disp_e,
                            input logic rd_e, input logic [15:0] cnt_e);
    check({tag, ".dvo"},   32'(bus.DVO),      32'(dvo_e));
    check({tag, ".do"},    32'(bus.DO),       32'(do_e));
    check({tag, ".k"},     32'(bus.K),        32'(k_e));
    check({tag, ".comma"}, 32'(bus.COMMA),    32'(comma_e));
    check({tag, ".code"},  32'(bus.CODE_ERR), 32'(code_e));
    check({tag, ".disp"},  32'(bus.DISP_ERR), 32'(disp_e));
    check({tag, ".rd"},    32'(bus.RD_OUT),   32'(rd_e));
    check({tag, ".cnt"},   32'(bus.ERR_CNT),  32'(cnt_e));
  endtask

  task automatic drive(input logic dvi, input logic [19:0] di, input logic clr);
    bus.DVI     = dvi;
    bus.DI      = di;
    bus.ERR_CLR = clr;
  endtask

  task automatic drive4(input logic dvi, input logic [19:0] di, input logic clr);
    bus4.DVI     = dvi;
    bus4.DI      = di;
    bus4.ERR_CLR = clr;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST      = 1'b1;
    drive (1'b1, {10'h3FF, 10'h3FF}, 1'b0);
    drive4(1'b0, {10'h3FF, 10'h3FF}, 1'b0);

    // Reset held two cycles with valid input present
    tick();
    tick();
    check_word("reset", 1'b0, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0);
    check("reset4.cnt", 32'(bus4.ERR_CNT), 32'd0);

    // K28.5 RD- then K28.5 RD+
    RST = 1'b0;
    drive(1'b1, {10'h305, 10'h0FA}, 1'b0);
    tick();
    check_word("k285_pair", 1'b1, 16'hBCBC, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 16'd0);

    // Two RD- K28.5 in a row: second lane conflicts with RD+
    drive(1'b1, {10'h0FA, 10'h0FA}, 1'b0);
    tick();
    check_word("k285_disp", 1'b1, 16'hBCBC, 2'b11, 2'b11, 2'b00, 2'b10, 1'b1, 16'd1);

    // D0.0 RD- column entering RD+: lane 0 flagged, lane 1 resynced
    drive(1'b1, {10'h274, 10'h274}, 1'b0);
    tick();
    check_word("d00_resync", 1'b1, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 16'd2);

    // Lane 0 invalid (also 4b disparity conflict), lane 1 D21.5; counts once
    drive(1'b1, {10'h2AA, 10'h3FF}, 1'b0);
    tick();
    check_word("code_err", 1'b1, 16'hB500, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1, 16'd3);

    // Word A from RD+: D0.0 RD+, K28.5 RD+
    drive(1'b1, {10'h305, 10'h18B}, 1'b0);
    tick();
    check_word("gap_a", 1'b1, 16'hBC00, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 16'd3);

    // Three idle cycles: outputs hold, DVO low
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, {10'h3FF, 10'h3FF}, 1'b0);
      tick();
      check_word("gap_idle", 1'b0, 16'hBC00, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 16'd3);
    end

    // Word B needs RD- carried across the gap
    drive(1'b1, {10'h2AA, 10'h0FA}, 1'b0);
    tick();
    check_word("gap_b", 1'b1, 16'hB5BC, 2'b00 | 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 16'd3);

    // D17.7 primary from RD+, then D17.A7 from RD-
    drive(1'b1, {10'h237, 10'h231}, 1'b0);
    tick();
    check_word("d17_7", 1'b1, 16'hF1F1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 16'd3);

    // K28.7 RD+ (comma), then K23.7 RD+ (not a comma)
    drive(1'b1, {10'h057, 10'h307}, 1'b0);
    tick();
    check_word("kx7", 1'b1, 16'hF7FC, 2'b11, 2'b01, 2'b00, 2'b00, 1'b1, 16'd3);

    // Illegal A7 after D0, and D7 RD- column entering RD+
    drive(1'b1, {10'h389, 10'h187}, 1'b0);
    tick();
    check_word("pairing", 1'b1, 16'h2700, 2'b00, 2'b00, 2'b01, 2'b10, 1'b1, 16'd5);

    // Mid-stream reset discards the word and restores RD_INIT
    RST = 1'b1;
    drive(1'b1, {10'h3FF, 10'h3FF}, 1'b0);
    tick();
    check_word("mid_rst", 1'b0, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0);
    RST = 1'b0;
    drive(1'b1, {10'h2AA, 10'h0FA}, 1'b0);
    tick();
    check_word("post_rst", 1'b1, 16'hB5BC, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 16'd0);
    drive(1'b0, {10'h000, 10'h000}, 1'b0);

    // Narrow counter: 2 errors per word saturates at 15
    for (int i = 0; i < 10; i++) begin
      drive4(1'b1, {10'h3FF, 10'h3FF}, 1'b0);
      tick();
      if (i == 6) check("sat.pre",  32'(bus4.ERR_CNT), 32'd14);
      if (i == 7) check("sat.edge", 32'(bus4.ERR_CNT), 32'd15);
    end
    check("sat.hold", 32'(bus4.ERR_CNT), 32'd15);
    check("sat.code", 32'(bus4.CODE_ERR), 32'd3);

    // Clear together with two error lanes
    drive4(1'b1, {10'h3FF, 10'h3FF}, 1'b1);
    tick();
    check("clr.two", 32'(bus4.ERR_CNT), 32'd2);

    // Clear together with one error lane
    drive4(1'b1, {10'h2AA, 10'h3FF}, 1'b1);
    tick();
    check("clr.one", 32'(bus4.ERR_CNT), 32'd1);
    check("clr.dvo", 32'(bus4.DVO), 32'd1);
    drive4(1'b0, {10'h000, 10'h000}, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
